muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Sequential RV32M multiply/divide unit; companion to the combinational ALU in the execute stage.
//  Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (op = funct3) with a start/busy/valid handshake.
//  Uses an iterative shift-add multiplier and a restoring divider, one bit per cycle, so it drops
//  into the datapath as a variable-latency execute unit.
// PARAMETERS
//  XLEN   32  operand/result width in bits; must be >= 4 and even
//  CNT_W  6   iteration counter width; must satisfy 2**CNT_W > XLEN
// PORTS
//  clk     in   1     rising-edge clock
//  reset   in   1     synchronous, active-high reset
//  start   in   1     request; accepted only when busy==0
//  op      in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  a       in   XLEN  rs1 operand (dividend / multiplicand), sampled on accept
//  b       in   XLEN  rs2 operand (divisor / multiplier), sampled on accept
//  busy    out  1     high from the cycle after accept until the valid cycle, inclusive
//  valid   out  1     one-cycle pulse; result is valid in that cycle
//  result  out  XLEN  registered result; held until the next accepted start
//  zero    out  1     (result == 0), combinational from the result register
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, valid=0, result=0, zero=1; all internal registers cleared.
//  - FSM: IDLE -> (start) MUL|DIV|DONE; MUL/DIV -> DONE after XLEN iterations; DONE -> IDLE.
//  - Accept: in IDLE with start=1, latch op/a/b, clear the counter, and take the sign of each operand
//    per op (signed: MULH, DIV, REM; rs1 only: MULHSU).
//  - Operands go into magnitude form and the result sign is fixed up in DONE (two's complement).
//  - MUL path: 2*XLEN product accumulator, one shift-add per cycle, XLEN cycles.
//    MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
//  - DIV path: restoring divide, one quotient bit per cycle, XLEN cycles.
//    Remainder takes the dividend's sign; quotient is negative iff the operand signs differ.
//  - Latency, normal op: accept at cycle T, valid=1 at T+XLEN+1; busy=1 over T+1..T+XLEN+1.
//  - Divide by zero, via fast path IDLE->DONE with valid at T+1:
//    quotient = all ones; remainder = a.
//  - Signed overflow (DIV/REM, a = 1<<(XLEN-1), b = all ones), fast path with valid at T+1:
//    DIV result = a; REM result = 0.
//  - start while busy=1 is ignored (no queueing). start in the DONE cycle is also ignored;
//    the earliest back-to-back accept is the cycle after valid.
//  - reset mid-operation aborts: FSM returns to IDLE next edge and outputs take reset values.
//  - Change of a/b/op after accept has no effect on the operation in flight.
// CONFIGURATION
//  - MULDIV_FAST_MUL_EN defined: MUL-class ops use a single-cycle 2*XLEN combinational multiply.
//    IDLE->DONE directly, valid at T+1, busy high only in T+1. DIV-class ops are unchanged.
//  - MULDIV_FAST_MUL_EN undefined: iterative multiplier as above, valid at T+XLEN+1.
// TESTING
//  1. MUL a=7, b=6 -> result=42, zero=0; valid exactly at T+33 (T+1 with FAST_MUL).
//  2. MULH a=0xFFFFFFFF(-1), b=0xFFFFFFFF -> 0x00000000, zero=1.
//     MULHU with the same operands -> 0xFFFFFFFE.
//  3. DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3).
//     REM with the same operands -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. DIVU a=123, b=0 -> 0xFFFFFFFF, valid at T+1.
//     REM a=123, b=0 -> 123.
//     DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
//  5. Assert start every cycle during a DIV -> exactly one valid per accepted op.
//     The second accept occurs the cycle after valid; the in-flight result is unaffected.
//  6. reset=1 at T+10 of a DIVU -> next cycle busy=0, valid=0, result=0.
//     A following MULHU 0x10000*0x10000 -> 0x00000001.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - sequential RV32M multiply/divide unit with start/busy/valid handshake
//
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// Both engines share one 2*XLEN working register:
//   multiply: {partial product, multiplier}, shifted right each cycle
//   divide:   {remainder, dividend/quotient}, shifted left each cycle
// Divide-by-zero and signed overflow finish through a one-cycle fast path.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   When defined, MUL-class ops use a single-cycle combinational multiply.
//
// Ports:
//   clk     in   1     rising-edge clock
//   reset   in   1     synchronous active-high reset
//   start   in   1     request, accepted only when idle
//   op      in   3     funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   a       in   XLEN  rs1 operand (multiplicand / dividend)
//   b       in   XLEN  rs2 operand (multiplier / divisor)
//   busy    out  1     high from the cycle after accept through the valid cycle
//   valid   out  1     one-cycle result pulse
//   result  out  XLEN  registered result
//   zero    out  1     result == 0

module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [2:0]        op_r;
    logic              neg_a_r;
    logic              neg_b_r;
    logic [XLEN-1:0]   opnd_r;   // multiplicand magnitude or divisor magnitude
    logic [2*XLEN-1:0] work_r;
    logic [CNT_W-1:0]  cnt_r;

    // Sign handling: signed operands are converted to magnitudes on accept and
    // the result sign is restored when the final value is written.
    function automatic logic [XLEN-1:0] fix_result(
        input logic [2:0]        o,
        input logic [2*XLEN-1:0] p,
        input logic              na,
        input logic              nb
    );
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   r;
        logic [2*XLEN-1:0] pp;
        logic [XLEN-1:0]   res;
        q   = p[XLEN-1:0];
        r   = p[2*XLEN-1:XLEN];
        pp  = (na ^ nb) ? -p : p;
        res = '0;
        if (o[2]) begin
            if (na ^ nb)
                q = -q;
            if (na)
                r = -r;
            res = o[1] ? r : q;
        end else begin
            res = (o == 3'b000) ? pp[XLEN-1:0] : pp[2*XLEN-1:XLEN];
        end
        return res;
    endfunction

    // ---------------- input decode (used only on accept) ----------------
    logic            accept;
    logic            is_div_in;
    logic            sa_in;
    logic            sb_in;
    logic            neg_a_in;
    logic            neg_b_in;
    logic [XLEN-1:0] mag_a_in;
    logic [XLEN-1:0] mag_b_in;
    logic            div_zero;
    logic            div_ovf;
    logic            fast_path;
    logic [XLEN-1:0] fast_res;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    always_comb begin
        accept    = (state == S_IDLE) && start;
        is_div_in = op[2];
        sa_in     = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        sb_in     = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        neg_a_in  = sa_in && a[XLEN-1];
        neg_b_in  = sb_in && b[XLEN-1];
        mag_a_in  = neg_a_in ? -a : a;
        mag_b_in  = neg_b_in ? -b : b;
        div_zero  = is_div_in && (b == '0);
        // Only the signed forms (DIV, REM) can overflow.
        div_ovf   = is_div_in && !op[0] && (a == MIN_NEG) && (b == ALL_ONES);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    always_comb begin
        fast_prod = {{XLEN{1'b0}}, mag_a_in} * {{XLEN{1'b0}}, mag_b_in};
        fast_path = !is_div_in || div_zero || div_ovf;
        fast_res  = '0;
        if (!is_div_in)
            fast_res = fix_result(op, fast_prod, neg_a_in, neg_b_in);
        else if (div_zero)
            fast_res = op[1] ? a : ALL_ONES;
        else if (div_ovf)
            fast_res = op[1] ? '0 : a;
    end
`else
    always_comb begin
        fast_path = div_zero || div_ovf;
        fast_res  = '0;
        if (div_zero)
            fast_res = op[1] ? a : ALL_ONES;
        else if (div_ovf)
            fast_res = op[1] ? '0 : a;
    end
`endif

    // ---------------- one-bit iteration step ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_nxt;
    logic [2*XLEN-1:0] iter_nxt;
    logic              last_iter;

    always_comb begin
        mul_sum   = {1'b0, work_r[2*XLEN-1:XLEN]} + (work_r[0] ? {1'b0, opnd_r} : '0);
        mul_nxt   = {mul_sum, work_r[XLEN-1:1]};
        // Bring the next dividend bit into the remainder, then trial-subtract.
        div_shift = {work_r[2*XLEN-1:XLEN], work_r[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_r};
        if (div_shift >= {1'b0, opnd_r})
            div_nxt = {div_diff[XLEN-1:0], work_r[XLEN-2:0], 1'b1};
        else
            div_nxt = {div_shift[XLEN-1:0], work_r[XLEN-2:0], 1'b0};
        iter_nxt  = (state == S_DIV) ? div_nxt : mul_nxt;
        last_iter = (cnt_r == CNT_W'(XLEN-1));
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (fast_path)
                        state_nxt = S_DONE;
                    else if (is_div_in)
                        state_nxt = S_DIV;
                    else
                        state_nxt = S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy  = (state != S_IDLE);
        valid = (state == S_DONE);
        zero  = (result == '0);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r    <= '0;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
            opnd_r  <= '0;
            work_r  <= '0;
            cnt_r   <= '0;
            result  <= '0;
        end else if (accept) begin
            op_r    <= op;
            neg_a_r <= neg_a_in;
            neg_b_r <= neg_b_in;
            cnt_r   <= '0;
            if (is_div_in) begin
                opnd_r <= mag_b_in;
                work_r <= {{XLEN{1'b0}}, mag_a_in};
            end else begin
                opnd_r <= mag_a_in;
                work_r <= {{XLEN{1'b0}}, mag_b_in};
            end
            if (fast_path)
                result <= fast_res;
        end else if ((state == S_MUL) || (state == S_DIV)) begin
            work_r <= iter_nxt;
            cnt_r  <= cnt_r + CNT_W'(1);
            // Write the final value on the last step so it is ready in DONE.
            if (last_iter)
                result <= fix_result(op_r, iter_nxt, neg_a_r, neg_b_r);
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit

module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic        zero;

    int checks   = 0;
    int failures = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT  = 33;
    localparam int FAST_LAT = 1;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .valid  (valid),
        .result (result),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op from a negedge, then scribble over the inputs to show the
    // op in flight is unaffected. Checks latency, result, zero and pulse shape.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int n;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op = ~o; a = 32'h5A5A_1234; b = 32'h0000_0003;
        n = 1;
        while (!valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_res"}, result, exp);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, (exp == 32'h0)});
        check({tag, "_busy"}, {31'b0, busy}, 32'h1);
        @(negedge clk);
        check({tag, "_pulse"}, {30'b0, valid, busy}, 32'h0);
    endtask

    initial begin
        int n;
        int nvalid;
        int v_at [2];
        logic [31:0] v_res [2];

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   {31'b0, busy},  32'h0);
        check("rst_valid",  {31'b0, valid}, 32'h0);
        check("rst_result", result,         32'h0);
        check("rst_zero",   {31'b0, zero},  32'h1);
        reset = 1'b0;
        @(negedge clk);

        run_op("mul_7x6",    3'b000, 32'd7,         32'd6,         32'd42,        MUL_LAT);
        run_op("mul_neg",    3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, MUL_LAT);
        run_op("mulh_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         MUL_LAT);
        run_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
        run_op("div_7_m2",   3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_7_m2",   3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT);
        run_op("divu_100_7", 3'b101, 32'd100,       32'd7,         32'd14,        DIV_LAT);
        run_op("remu_100_7", 3'b111, 32'd100,       32'd7,         32'd2,         DIV_LAT);
        run_op("divu_by0",   3'b101, 32'd123,       32'd0,         32'hFFFF_FFFF, FAST_LAT);
        run_op("rem_by0",    3'b110, 32'd123,       32'd0,         32'd123,       FAST_LAT);
        run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FAST_LAT);
        run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         FAST_LAT);

        // start held high across a DIVU; operands change mid-flight.
        op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
        nvalid = 0; v_at[0] = 0; v_at[1] = 0; v_res[0] = '0; v_res[1] = '0;
        @(posedge clk);
        for (n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (n == 3) begin
                a = 32'd200; b = 32'd10;
            end
            if (n == 35)
                start = 1'b0;
            if (valid) begin
                if (nvalid < 2) begin
                    v_at[nvalid]  = n;
                    v_res[nvalid] = result;
                end
                nvalid++;
            end
        end
        check("b2b_count", 32'(nvalid),  32'd2);
        check("b2b_lat0",  32'(v_at[0]), 32'd33);
        check("b2b_res0",  v_res[0],     32'd14);
        check("b2b_lat1",  32'(v_at[1]), 32'd67);
        check("b2b_res1",  v_res[1],     32'd20);

        // Reset in the middle of a DIVU.
        @(negedge clk);
        op = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (n = 1; n < 10; n++)
            @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",   {31'b0, busy},  32'h0);
        check("abort_valid",  {31'b0, valid}, 32'h0);
        check("abort_result", result,         32'h0);
        run_op("mulhu_2p32", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h1, MUL_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
